// File: rtl/adc_pulse_generator_pkg.sv
// Shared constants and state type for the synthetic ADC pulse source.
// SIZE_ADC_DATA is the same sample width the shaping filter consumes.
package adc_pulse_generator_pkg;

    localparam int SIZE_ADC_DATA = 12;
    localparam int SIZE_AMP      = 12;
    localparam int BASELINE      = 100;
    localparam int RISE_SHIFT    = 2;
    localparam int DECAY_SHIFT   = 3;
    localparam int SIZE_PERIOD   = 16;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        DECAY
    } gen_state_t;

endpackage

// File: rtl/adc_pulse_period_timer.sv
// Auto-trigger period counter; merges its wrap event with the external trigger.
module adc_pulse_period_timer #(
    parameter int SIZE_PERIOD = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   trigger,
    input  logic [SIZE_PERIOD-1:0] period,
    output logic                   start
);

    logic [SIZE_PERIOD-1:0] timer_q;
    logic [SIZE_PERIOD-1:0] timer_d;
    logic [SIZE_PERIOD-1:0] period_last;
    logic                   auto_on;
    logic                   period_hit;

    always_comb begin
        auto_on     = (period != '0);
        period_last = period - SIZE_PERIOD'(1);
        period_hit  = auto_on && (timer_q == period_last);
        start       = enable && (trigger || period_hit);

        // >= keeps the counter bounded if period is shortened mid-count
        if (!enable || !auto_on) begin
            timer_d = '0;
        end else if (timer_q >= period_last) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + SIZE_PERIOD'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/adc_pulse_generator.sv
// Synthetic detector pulse source: linear rise then exponential decay on a baseline,
// with pile-up onto decaying tails and saturation of the output code.
module adc_pulse_generator #(
    parameter int SIZE_ADC_DATA = adc_pulse_generator_pkg::SIZE_ADC_DATA,
    parameter int SIZE_AMP      = adc_pulse_generator_pkg::SIZE_AMP,
    parameter int BASELINE      = adc_pulse_generator_pkg::BASELINE,
    parameter int RISE_SHIFT    = adc_pulse_generator_pkg::RISE_SHIFT,
    parameter int DECAY_SHIFT   = adc_pulse_generator_pkg::DECAY_SHIFT,
    parameter int SIZE_PERIOD   = adc_pulse_generator_pkg::SIZE_PERIOD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     trigger,
    input  logic [SIZE_AMP-1:0]      amplitude,
    input  logic [SIZE_PERIOD-1:0]   period,
    output logic [SIZE_ADC_DATA-1:0] adc_data,
    output logic                     valid,
    output logic                     busy,
    output logic                     clip,
    output logic [7:0]               pileup_count
);

    import adc_pulse_generator_pkg::*;

    localparam int V_W   = SIZE_ADC_DATA + 1;
    localparam int CNT_W = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    localparam int RS_W  = V_W + SIZE_AMP + CNT_W + 1;
    localparam int OS_W  = V_W + 1;

    localparam logic [V_W-1:0]           V_MAX     = {V_W{1'b1}};
    localparam logic [SIZE_ADC_DATA-1:0] OUT_MAX   = {SIZE_ADC_DATA{1'b1}};
    localparam logic [SIZE_ADC_DATA-1:0] BASE_CODE = SIZE_ADC_DATA'(BASELINE);
    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'((1 << RISE_SHIFT) - 1);

    // Rise sample computed from the pulse base so saturation never accumulates error
    function automatic logic [V_W-1:0] rise_value(
        input logic [V_W-1:0]      base,
        input logic [SIZE_AMP-1:0] step,
        input logic [CNT_W-1:0]    cnt
    );
        logic [RS_W-1:0] sum;
        sum = RS_W'(base) + RS_W'(step) * (RS_W'(cnt) + RS_W'(1));
        return (sum > RS_W'(V_MAX)) ? V_MAX : sum[V_W-1:0];
    endfunction

    function automatic logic [OS_W-1:0] out_sum(input logic [V_W-1:0] v);
        return OS_W'(BASE_CODE) + OS_W'(v);
    endfunction

    gen_state_t              state_q, state_d;
    logic [V_W-1:0]          v_q, v_d;
    logic [V_W-1:0]          v_base_q, v_base_d;
    logic [SIZE_AMP-1:0]     step_q, step_d;
    logic [CNT_W-1:0]        rise_cnt_q, rise_cnt_d;
    logic [7:0]              pileup_q, pileup_d;
    logic [SIZE_ADC_DATA-1:0] adc_data_q, adc_data_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    clip_q, clip_d;

    logic                    start;
    logic [V_W-1:0]          decay_tail;
    logic [OS_W-1:0]         sum_out;

    adc_pulse_period_timer #(
        .SIZE_PERIOD (SIZE_PERIOD)
    ) u_period_timer (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .trigger (trigger),
        .period  (period),
        .start   (start)
    );

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        v_base_d   = v_base_q;
        step_d     = step_q;
        rise_cnt_d = rise_cnt_q;
        pileup_d   = pileup_q;
        decay_tail = v_q >> DECAY_SHIFT;

        if (!enable) begin
            state_d = IDLE;
            v_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        step_d     = amplitude >> RISE_SHIFT;
                        v_base_d   = '0;
                        rise_cnt_d = '0;
                        state_d    = RISE;
                    end
                end
                RISE: begin
                    v_d        = rise_value(v_base_q, step_q, rise_cnt_q);
                    rise_cnt_d = rise_cnt_q + CNT_W'(1);
                    if (rise_cnt_q == CNT_LAST) begin
                        state_d = DECAY;
                    end
                end
                DECAY: begin
                    if (decay_tail == '0) begin
                        // Tail exhausted: a coincident start is a fresh pulse, not pile-up
                        v_d     = '0;
                        state_d = IDLE;
                        if (start) begin
                            step_d     = amplitude >> RISE_SHIFT;
                            v_base_d   = '0;
                            rise_cnt_d = '0;
                            state_d    = RISE;
                        end
                    end else if (start) begin
                        step_d     = amplitude >> RISE_SHIFT;
                        v_base_d   = v_q;
                        rise_cnt_d = '0;
                        state_d    = RISE;
                        if (pileup_q != 8'hFF) begin
                            pileup_d = pileup_q + 8'd1;
                        end
                    end else begin
                        v_d = v_q - decay_tail;
                    end
                end
                default: begin
                    state_d = IDLE;
                    v_d     = '0;
                end
            endcase
        end

        sum_out    = out_sum(v_d);
        clip_d     = (sum_out > OS_W'(OUT_MAX));
        adc_data_d = clip_d ? OUT_MAX : sum_out[SIZE_ADC_DATA-1:0];
        valid_d    = enable;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            v_q        <= '0;
            v_base_q   <= '0;
            step_q     <= '0;
            rise_cnt_q <= '0;
            pileup_q   <= '0;
            adc_data_q <= BASE_CODE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            v_base_q   <= v_base_d;
            step_q     <= step_d;
            rise_cnt_q <= rise_cnt_d;
            pileup_q   <= pileup_d;
            adc_data_q <= adc_data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            clip_q     <= clip_d;
        end
    end

    assign adc_data     = adc_data_q;
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign clip         = clip_q;
    assign pileup_count = pileup_q;

endmodule
